// File: rtl/dmem_responder_pkg.sv
// Shared types and MMIO addresses for the Memory-stage data-bus responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmemState_;

  localparam logic [31:0] MMIO_COUNTER_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_CONSOLE_ADDR = 32'hFFFF_0004;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage data bus: request side driven by the initiator, responses by dmem_responder.
interface dmem_responder_if;

  logic [31:0] address;
  logic [31:0] storeData;
  logic [3:0]  byteEnable;
  logic        storeValid;
  logic        loadRequest;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        outOfRange;
  logic        busy;

  modport master (
    output address, storeData, byteEnable, storeValid, loadRequest,
    input  loadData, loadDataValid, storeComplete, outOfRange, busy
  );

  modport slave (
    input  address, storeData, byteEnable, storeValid, loadRequest,
    output loadData, loadDataValid, storeComplete, outOfRange, busy
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word-organised RAM with byte-lane write enables and registered read.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter              INIT_FILE   = "",
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          writeEnable,
  input  logic          readEnable,
  input  logic [AW-1:0] wordIndex,
  input  logic [31:0]   writeData,
  input  logic [3:0]    byteEnable,
  output logic [31:0]   readData
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (writeEnable) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byteEnable[b]) mem[wordIndex][8*b +: 8] <= writeData[8*b +: 8];
      end
    end
    if (readEnable) readData <= mem[wordIndex];
  end

endmodule

// File: rtl/dmem_responder.sv
// Slow data-memory responder: fixed-latency load/store service over dmem_responder_if.
// Optional DMEM_MMIO_EN adds a cycle-counter word and a console output port.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
`ifdef DMEM_MMIO_EN
  ,
  output logic             consoleValid,
  output logic [7:0]       consoleData
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmemState_   state, nextState;
  logic [3:0]  count;
  logic [31:2] wordQ;
  logic [31:0] dataQ;
  logic [3:0]  beQ;
  logic        storeQ;
  logic        oorQ;
  logic        useRam;
  logic [31:0] loadDataQ;
  logic [31:0] ramData;

  logic        accept, enterResp;
  logic [31:2] curWord;
  logic [31:0] curData;
  logic [3:0]  curBe;
  logic        curStore;
  logic        rangeHit, counterHit, consoleHit, mmioHit, ramHit;
  logic        ramWe, ramRe;

  // With LATENCY=1 the RAM is accessed on the accept edge itself, before the
  // latched copies exist, so the access uses the live bus while IDLE.
  always_comb begin
    if (state == IDLE) begin
      curWord  = bus.address[31:2];
      curData  = bus.storeData;
      curBe    = bus.byteEnable;
      curStore = bus.storeValid;
    end else begin
      curWord  = wordQ;
      curData  = dataQ;
      curBe    = beQ;
      curStore = storeQ;
    end
  end

  assign rangeHit = |curWord[31:AW+2];

`ifdef DMEM_MMIO_EN
  logic [31:0] cycleCount;
  logic        consoleFireQ;

  assign counterHit = (curWord == MMIO_COUNTER_ADDR[31:2]);
  assign consoleHit = (curWord == MMIO_CONSOLE_ADDR[31:2]);
`else
  assign counterHit = 1'b0;
  assign consoleHit = 1'b0;
`endif

  assign mmioHit = counterHit | consoleHit;
  assign ramHit  = !rangeHit && !mmioHit;
  assign ramWe   = enterResp && curStore && ramHit && reset;
  assign ramRe   = enterResp && !curStore && ramHit && reset;

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    enterResp = 1'b0;
    case (state)
      IDLE: begin
        if (bus.storeValid || bus.loadRequest) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            nextState = RESP;
            enterResp = 1'b1;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (count == 4'd1) begin
          nextState = RESP;
          enterResp = 1'b1;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      wordQ     <= '0;
      dataQ     <= '0;
      beQ       <= '0;
      storeQ    <= 1'b0;
      oorQ      <= 1'b0;
      useRam    <= 1'b0;
      loadDataQ <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        wordQ  <= bus.address[31:2];
        dataQ  <= bus.storeData;
        beQ    <= bus.byteEnable;
        storeQ <= bus.storeValid;
        count  <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
      if (enterResp) begin
        oorQ <= rangeHit && !mmioHit;
        if (!curStore) begin
          useRam <= ramHit;
`ifdef DMEM_MMIO_EN
          loadDataQ <= counterHit ? cycleCount : '0;
`else
          loadDataQ <= '0;
`endif
        end
      end
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycleCount   <= '0;
      consoleFireQ <= 1'b0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
      if (enterResp) consoleFireQ <= curStore && consoleHit && curBe[0];
    end
  end

  assign consoleValid = (state == RESP) && consoleFireQ;
  assign consoleData  = dataQ[7:0];
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) uArray (
    .clock       (clock),
    .writeEnable (ramWe),
    .readEnable  (ramRe),
    .wordIndex   (curWord[AW+1:2]),
    .writeData   (curData),
    .byteEnable  (curBe),
    .readData    (ramData)
  );

  assign bus.loadData      = useRam ? ramData : loadDataQ;
  assign bus.loadDataValid = (state == RESP) && !storeQ;
  assign bus.storeComplete = (state == RESP) && storeQ;
  assign bus.outOfRange    = (state == RESP) && oorQ;
  assign bus.busy          = (state != IDLE);

  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.address[1:0];

endmodule
